// File: rtl/lc3_disp_uart.sv
// LC-3 display stage: captures DDR writes, returns DSR, sends 8N1 UART.
// Define LC3_DISP_FIFO_EN for a 4-entry queue instead of one holding register.
module lc3_disp_uart #(
  parameter int CLK_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ddr_data,
  input  logic        ddr_wr,
  output logic [15:0] dsr,
  output logic        tx,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [15:0] BAUD_TOP = 16'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        ovr_q, ovr_d;

  logic        wr_acc;
  logic        pop;
  logic        buf_empty;
  logic [7:0]  buf_head;

  // Only the low byte goes on the wire
  logic unused_hi;
  assign unused_hi = ^ddr_data[15:8];

  assign wr_acc = ddr_wr & ready_q;
  assign pop    = (state_q == S_IDLE) & ~buf_empty;

`ifdef LC3_DISP_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wp_q, rp_q;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + {2'b00, wr_acc} - {2'b00, pop};
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wp_q] <= ddr_data[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= 2'd0;
      rp_q  <= 2'd0;
      cnt_q <= 3'd0;
    end else begin
      if (wr_acc) begin
        wp_q <= wp_q + 2'd1;
      end
      if (pop) begin
        rp_q <= rp_q + 2'd1;
      end
      cnt_q <= cnt_d;
    end
  end

  assign buf_empty = (cnt_q == 3'd0);
  assign buf_head  = mem_q[rp_q];
  assign ready_d   = (cnt_d != 3'd4);
`else
  logic [7:0] hold_q;
  logic       full_q, full_d;

  always_comb begin
    full_d = wr_acc | (full_q & ~pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 8'h00;
      full_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        hold_q <= ddr_data[7:0];
      end
      full_q <= full_d;
    end
  end

  assign buf_empty = ~full_q;
  assign buf_head  = hold_q;
  assign ready_d   = ~full_d;
`endif

  assign ovr_d = ovr_q | (ddr_wr & ~ready_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_START;
          shift_d = buf_head;
          baud_d  = BAUD_TOP;
          bit_d   = 3'd0;
        end
      end
      S_START: begin
        if (baud_q == 16'd0) begin
          state_d = S_DATA;
          baud_d  = BAUD_TOP;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_q == 16'd0) begin
          shift_d = {1'b0, shift_q[7:1]};
          baud_d  = BAUD_TOP;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (baud_q == 16'd0) begin
          state_d = S_IDLE;
          baud_d  = 16'd0;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
    endcase
  end

  // Line level is registered from the next state so tx changes with the state
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_STOP:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      tx_q    <= tx_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE);
  assign dsr  = {ready_q, ovr_q, 14'h0000};

endmodule
